// File: rtl/vc_pkg.sv
// Shared types and defaults for the victim cache controller.
package vc_pkg;

  localparam int VC_ENTRIES_DEF     = 4;
  localparam int LINE_ADDR_BITS_DEF = 26;

  typedef enum logic [2:0] {
    VC_IDLE     = 3'd0,
    VC_SWAP     = 3'd1,
    VC_WB       = 3'd2,
    VC_INSERT   = 3'd3,
    VC_FLUSH    = 3'd4,
    VC_FLUSH_WB = 3'd5,
    VC_DONE     = 3'd6
  } type_vc_states_e;

  typedef struct packed {
    logic                          valid;
    logic                          dirty;
    logic [LINE_ADDR_BITS_DEF-1:0] line_addr;
  } type_vc_tag_s;

endpackage

// File: rtl/vc_tag_match.sv
// Parallel tag compare with lowest-index priority encoding for hits and free slots.
module vc_tag_match #(
  parameter int ENTRIES   = 4,
  parameter int ADDR_BITS = 26,
  parameter int IDX_BITS  = 2
) (
  input  logic [ENTRIES-1:0]           valid_i,
  input  logic [ENTRIES*ADDR_BITS-1:0] tags_i,
  input  logic [ADDR_BITS-1:0]         addr_i,
  output logic                         hit_o,
  output logic [IDX_BITS-1:0]          hit_idx_o,
  output logic                         any_invalid_o,
  output logic [IDX_BITS-1:0]          first_invalid_idx_o
);

  logic [ENTRIES-1:0] match_s;

  // Per-entry tag equality qualified by valid.
  always_comb begin
    match_s = {ENTRIES{1'b0}};
    for (int i = 0; i < ENTRIES; i++) begin
      match_s[i] = valid_i[i] && (tags_i[i*ADDR_BITS +: ADDR_BITS] == addr_i);
    end
  end

  // Downward scan so the lowest matching / invalid index wins.
  always_comb begin
    hit_idx_o           = {IDX_BITS{1'b0}};
    first_invalid_idx_o = {IDX_BITS{1'b0}};
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match_s[i]) begin
        hit_idx_o = IDX_BITS'(i);
      end else begin
        hit_idx_o = hit_idx_o;
      end
      if (!valid_i[i]) begin
        first_invalid_idx_o = IDX_BITS'(i);
      end else begin
        first_invalid_idx_o = first_invalid_idx_o;
      end
    end
    hit_o         = |match_s;
    any_invalid_o = ~&valid_i;
  end

endmodule

// File: rtl/victim_cache_ctrl.sv
// Victim cache controller: tag/valid/dirty state, data array sequencing and
// write-back of displaced dirty victims over the dcache memory handshake.
module victim_cache_ctrl
  import vc_pkg::*;
#(
  parameter int VC_ENTRIES     = VC_ENTRIES_DEF,
  parameter int LINE_ADDR_BITS = LINE_ADDR_BITS_DEF,
  parameter int VC_IDX_BITS    = $clog2(VC_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LINE_ADDR_BITS-1:0] lookup_addr_i,
  output logic                      vc_hit_o,
  output logic [VC_IDX_BITS-1:0]    vc_hit_idx_o,
  input  logic                      swap_req_i,
  input  logic                      insert_req_i,
  input  logic                      evict_valid_i,
  input  logic                      evict_dirty_i,
  input  logic [LINE_ADDR_BITS-1:0] evict_addr_i,
  input  logic                      vc_flush_i,
  input  logic                      kill_i,
  output logic                      vc_data_rd_o,
  output logic                      vc_data_wr_o,
  output logic [VC_IDX_BITS-1:0]    vc_idx_o,
  output logic                      vc2dcache_ack_o,
  output logic                      vc_busy_o,
  output logic                      vc2mem_req_o,
  output logic                      vc2mem_wr_o,
  output logic [LINE_ADDR_BITS-1:0] vc2mem_addr_o,
  output logic                      vc2mem_kill_o,
  input  logic                      mem2vc_ack_i
);

  localparam logic [VC_IDX_BITS-1:0] LAST_IDX = VC_IDX_BITS'(VC_ENTRIES - 1);

  type_vc_states_e           state_q, state_d;
  logic [VC_ENTRIES-1:0]     valid_q, valid_d;
  logic [VC_ENTRIES-1:0]     dirty_q, dirty_d;
  logic [LINE_ADDR_BITS-1:0] tag_q [VC_ENTRIES];
  logic [LINE_ADDR_BITS-1:0] tag_d [VC_ENTRIES];
  logic [VC_IDX_BITS-1:0]    fifo_ptr_q, fifo_ptr_d;
  logic [VC_IDX_BITS-1:0]    target_q, target_d;
  logic                      from_fifo_q, from_fifo_d;
  logic [VC_IDX_BITS-1:0]    scan_idx_q, scan_idx_d;
  logic [LINE_ADDR_BITS-1:0] evict_addr_q, evict_addr_d;
  logic                      evict_dirty_q, evict_dirty_d;
  logic                      ack_q, ack_d;

  logic [VC_ENTRIES*LINE_ADDR_BITS-1:0] tags_flat_s;
  logic                                 hit_s;
  logic [VC_IDX_BITS-1:0]               hit_idx_s;
  logic                                 any_inv_s;
  logic [VC_IDX_BITS-1:0]               first_inv_s;
  logic [VC_IDX_BITS-1:0]               ins_target_s;

  // Flatten the tag array for the matcher.
  always_comb begin
    tags_flat_s = {(VC_ENTRIES*LINE_ADDR_BITS){1'b0}};
    for (int i = 0; i < VC_ENTRIES; i++) begin
      tags_flat_s[i*LINE_ADDR_BITS +: LINE_ADDR_BITS] = tag_q[i];
    end
  end

  vc_tag_match #(
    .ENTRIES  (VC_ENTRIES),
    .ADDR_BITS(LINE_ADDR_BITS),
    .IDX_BITS (VC_IDX_BITS)
  ) u_tag_match (
    .valid_i            (valid_q),
    .tags_i             (tags_flat_s),
    .addr_i             (lookup_addr_i),
    .hit_o              (hit_s),
    .hit_idx_o          (hit_idx_s),
    .any_invalid_o      (any_inv_s),
    .first_invalid_idx_o(first_inv_s)
  );

  assign vc_hit_o     = hit_s;
  assign vc_hit_idx_o = hit_idx_s;
  assign vc_busy_o    = (state_q != VC_IDLE);
  // A full cache falls back to round-robin replacement.
  assign ins_target_s = any_inv_s ? first_inv_s : fifo_ptr_q;

  // Next-state, entry updates and output strobes.
  always_comb begin
    state_d         = state_q;
    valid_d         = valid_q;
    dirty_d         = dirty_q;
    tag_d           = tag_q;
    fifo_ptr_d      = fifo_ptr_q;
    target_d        = target_q;
    from_fifo_d     = from_fifo_q;
    scan_idx_d      = scan_idx_q;
    evict_addr_d    = evict_addr_q;
    evict_dirty_d   = evict_dirty_q;
    ack_d           = 1'b0;
    vc_data_rd_o    = 1'b0;
    vc_data_wr_o    = 1'b0;
    vc_idx_o        = {VC_IDX_BITS{1'b0}};
    vc2dcache_ack_o = ack_q;
    vc2mem_req_o    = 1'b0;
    vc2mem_wr_o     = 1'b0;
    vc2mem_addr_o   = {LINE_ADDR_BITS{1'b0}};
    vc2mem_kill_o   = 1'b0;

    case (state_q)
      VC_IDLE: begin
        if (vc_flush_i) begin
          scan_idx_d = {VC_IDX_BITS{1'b0}};
          state_d    = VC_FLUSH;
        end else if (swap_req_i && hit_s) begin
          vc_data_rd_o = 1'b1;
          vc_idx_o     = hit_idx_s;
          target_d     = hit_idx_s;
          state_d      = VC_SWAP;
        end else if (insert_req_i) begin
          if (!evict_valid_i) begin
            ack_d = 1'b1;
          end else begin
            target_d      = ins_target_s;
            from_fifo_d   = ~any_inv_s;
            evict_addr_d  = evict_addr_i;
            evict_dirty_d = evict_dirty_i;
            if (valid_q[ins_target_s] && dirty_q[ins_target_s]) begin
              state_d = VC_WB;
            end else begin
              state_d = VC_INSERT;
            end
          end
        end else begin
          state_d = VC_IDLE;
        end
      end

      // Swap ack is registered so it lands two cycles after the request.
      VC_SWAP: begin
        if (kill_i) begin
          state_d = VC_IDLE;
        end else begin
          vc_idx_o = target_q;
          if (evict_valid_i) begin
            tag_d[target_q]   = evict_addr_i;
            dirty_d[target_q] = evict_dirty_i;
            valid_d[target_q] = 1'b1;
            vc_data_wr_o      = 1'b1;
          end else begin
            valid_d[target_q] = 1'b0;
            dirty_d[target_q] = 1'b0;
          end
          ack_d   = 1'b1;
          state_d = VC_IDLE;
        end
      end

      VC_WB: begin
        if (kill_i) begin
          vc2mem_kill_o = 1'b1;
          state_d       = VC_IDLE;
        end else begin
          vc2mem_req_o  = 1'b1;
          vc2mem_wr_o   = 1'b1;
          vc2mem_addr_o = tag_q[target_q];
          vc_data_rd_o  = 1'b1;
          vc_idx_o      = target_q;
          if (mem2vc_ack_i) begin
            state_d = VC_INSERT;
          end else begin
            state_d = VC_WB;
          end
        end
      end

      VC_INSERT: begin
        if (kill_i) begin
          state_d = VC_IDLE;
        end else begin
          tag_d[target_q]   = evict_addr_q;
          dirty_d[target_q] = evict_dirty_q;
          valid_d[target_q] = 1'b1;
          vc_data_wr_o      = 1'b1;
          vc_idx_o          = target_q;
          vc2dcache_ack_o   = 1'b1;
          if (from_fifo_q) begin
            fifo_ptr_d = fifo_ptr_q + VC_IDX_BITS'(1);
          end else begin
            fifo_ptr_d = fifo_ptr_q;
          end
          state_d = VC_IDLE;
        end
      end

      VC_FLUSH: begin
        if (kill_i) begin
          state_d = VC_IDLE;
        end else if (valid_q[scan_idx_q] && dirty_q[scan_idx_q]) begin
          state_d = VC_FLUSH_WB;
        end else begin
          valid_d[scan_idx_q] = 1'b0;
          dirty_d[scan_idx_q] = 1'b0;
          if (scan_idx_q == LAST_IDX) begin
            state_d = VC_DONE;
          end else begin
            scan_idx_d = scan_idx_q + VC_IDX_BITS'(1);
            state_d    = VC_FLUSH;
          end
        end
      end

      VC_FLUSH_WB: begin
        if (kill_i) begin
          vc2mem_kill_o = 1'b1;
          state_d       = VC_IDLE;
        end else begin
          vc2mem_req_o  = 1'b1;
          vc2mem_wr_o   = 1'b1;
          vc2mem_addr_o = tag_q[scan_idx_q];
          vc_data_rd_o  = 1'b1;
          vc_idx_o      = scan_idx_q;
          if (mem2vc_ack_i) begin
            valid_d[scan_idx_q] = 1'b0;
            dirty_d[scan_idx_q] = 1'b0;
            if (scan_idx_q == LAST_IDX) begin
              state_d = VC_DONE;
            end else begin
              scan_idx_d = scan_idx_q + VC_IDX_BITS'(1);
              state_d    = VC_FLUSH;
            end
          end else begin
            state_d = VC_FLUSH_WB;
          end
        end
      end

      VC_DONE: begin
        if (kill_i) begin
          state_d = VC_IDLE;
        end else begin
          vc2dcache_ack_o = 1'b1;
          fifo_ptr_d      = {VC_IDX_BITS{1'b0}};
          state_d         = VC_IDLE;
        end
      end

      default: begin
        state_d = VC_IDLE;
      end
    endcase
  end

  // State and entry registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= VC_IDLE;
      valid_q       <= {VC_ENTRIES{1'b0}};
      dirty_q       <= {VC_ENTRIES{1'b0}};
      fifo_ptr_q    <= {VC_IDX_BITS{1'b0}};
      target_q      <= {VC_IDX_BITS{1'b0}};
      from_fifo_q   <= 1'b0;
      scan_idx_q    <= {VC_IDX_BITS{1'b0}};
      evict_addr_q  <= {LINE_ADDR_BITS{1'b0}};
      evict_dirty_q <= 1'b0;
      ack_q         <= 1'b0;
      for (int i = 0; i < VC_ENTRIES; i++) begin
        tag_q[i] <= {LINE_ADDR_BITS{1'b0}};
      end
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      dirty_q       <= dirty_d;
      fifo_ptr_q    <= fifo_ptr_d;
      target_q      <= target_d;
      from_fifo_q   <= from_fifo_d;
      scan_idx_q    <= scan_idx_d;
      evict_addr_q  <= evict_addr_d;
      evict_dirty_q <= evict_dirty_d;
      ack_q         <= ack_d;
      tag_q         <= tag_d;
    end
  end

endmodule

// File: tb/tb_victim_cache_ctrl.sv
// Directed bench for victim_cache_ctrl: an entry-level model drives per-cycle
// expectations that one negedge process compares against the DUT.
module tb_victim_cache_ctrl;
  import vc_pkg::*;

  localparam int N = 4;
  localparam int W = 26;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] lookup_addr;
  logic         vc_hit;
  logic [1:0]   vc_hit_idx;
  logic         swap_req, insert_req, evict_valid, evict_dirty;
  logic [W-1:0] evict_addr;
  logic         vc_flush, kill;
  logic         data_rd, data_wr;
  logic [1:0]   vc_idx;
  logic         ack, busy, mreq, mwr;
  logic [W-1:0] maddr;
  logic         mkill, mem_ack;

  victim_cache_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lookup_addr_i  (lookup_addr),
    .vc_hit_o       (vc_hit),
    .vc_hit_idx_o   (vc_hit_idx),
    .swap_req_i     (swap_req),
    .insert_req_i   (insert_req),
    .evict_valid_i  (evict_valid),
    .evict_dirty_i  (evict_dirty),
    .evict_addr_i   (evict_addr),
    .vc_flush_i     (vc_flush),
    .kill_i         (kill),
    .vc_data_rd_o   (data_rd),
    .vc_data_wr_o   (data_wr),
    .vc_idx_o       (vc_idx),
    .vc2dcache_ack_o(ack),
    .vc_busy_o      (busy),
    .vc2mem_req_o   (mreq),
    .vc2mem_wr_o    (mwr),
    .vc2mem_addr_o  (maddr),
    .vc2mem_kill_o  (mkill),
    .mem2vc_ack_i   (mem_ack)
  );

  always #5 clk = ~clk;

  // Model of the victim entries and replacement pointer.
  type_vc_tag_s m_ent [N];
  int           m_fifo;
  logic [W-1:0] wb_q [$];

  logic         e_rd, e_wr, e_ack, e_busy, e_req, e_mwr, e_mkill;
  logic [1:0]   e_idx;
  logic [W-1:0] e_maddr;
  bit           chk_en = 1'b0;
  int           n_chk = 0;
  int           n_err = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(swap_req && insert_req)) else $error("swap and insert requested together");
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic       mh;
      logic [1:0] mi;
      mh = 1'b0;
      mi = 2'd0;
      for (int i = N - 1; i >= 0; i--) begin
        if (m_ent[i].valid && m_ent[i].line_addr == lookup_addr) begin
          mh = 1'b1;
          mi = 2'(i);
        end
      end
      chk("hit", {31'd0, vc_hit}, {31'd0, mh});
      if (mh) chk("hit_idx", {30'd0, vc_hit_idx}, {30'd0, mi});
      chk("data_rd", {31'd0, data_rd}, {31'd0, e_rd});
      chk("data_wr", {31'd0, data_wr}, {31'd0, e_wr});
      chk("ack", {31'd0, ack}, {31'd0, e_ack});
      chk("busy", {31'd0, busy}, {31'd0, e_busy});
      chk("mem_req", {31'd0, mreq}, {31'd0, e_req});
      chk("mem_wr", {31'd0, mwr}, {31'd0, e_mwr});
      chk("mem_kill", {31'd0, mkill}, {31'd0, e_mkill});
      if (e_rd || e_wr) chk("vc_idx", {30'd0, vc_idx}, {30'd0, e_idx});
      if (e_req) chk("mem_addr", {6'd0, maddr}, {6'd0, e_maddr});
    end
  end

  task automatic clr_exp();
    e_rd = 1'b0; e_wr = 1'b0; e_ack = 1'b0; e_busy = 1'b0;
    e_req = 1'b0; e_mwr = 1'b0; e_mkill = 1'b0;
    e_idx = 2'd0; e_maddr = 26'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clr_exp();
    repeat (n) tick();
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    swap_req = 1'b0; insert_req = 1'b0; evict_valid = 1'b0; evict_dirty = 1'b0;
    evict_addr = 26'd0; vc_flush = 1'b0; kill = 1'b0; mem_ack = 1'b0;
    lookup_addr = 26'd0;
    clr_exp();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) m_ent[i] = '{valid: 1'b0, dirty: 1'b0, line_addr: 26'd0};
    m_fifo = 0;
    wb_q.delete();
    chk_en = 1'b1;
  endtask

  task automatic look(input string nm, input logic [W-1:0] a, input logic h, input logic [1:0] idx);
    lookup_addr = a;
    @(negedge clk);
    chk({nm, "_hit"}, {31'd0, vc_hit}, {31'd0, h});
    if (h) chk({nm, "_idx"}, {30'd0, vc_hit_idx}, {30'd0, idx});
    tick();
  endtask

  // Insert one evicted line; killat>0 raises kill_i in that write-back cycle.
  task automatic do_insert(input logic [W-1:0] a, input logic d, input logic v,
                           input int memdly, input int killat);
    int tgt;
    bit ff, wb, killed;
    tgt = -1;
    for (int i = 0; i < N; i++) if (!m_ent[i].valid && tgt < 0) tgt = i;
    ff = (tgt < 0);
    if (ff) tgt = m_fifo;
    wb = m_ent[tgt].valid && m_ent[tgt].dirty;
    killed = 1'b0;
    insert_req = 1'b1; evict_valid = v; evict_dirty = d; evict_addr = a;
    clr_exp();
    tick();
    insert_req = 1'b0;
    if (!v) begin
      e_ack = 1'b1;
      tick();
    end else begin
      if (wb) begin
        wb_q.push_back(m_ent[tgt].line_addr);
        for (int c = 1; c <= memdly && !killed; c++) begin
          clr_exp();
          e_busy = 1'b1; e_req = 1'b1; e_mwr = 1'b1; e_rd = 1'b1;
          e_idx = 2'(tgt); e_maddr = m_ent[tgt].line_addr;
          mem_ack = (c == memdly);
          if (c == killat) begin
            kill = 1'b1; mem_ack = 1'b0;
            e_req = 1'b0; e_mwr = 1'b0; e_rd = 1'b0; e_mkill = 1'b1;
            killed = 1'b1;
          end
          tick();
          mem_ack = 1'b0;
          kill = 1'b0;
        end
      end
      if (killed) begin
        idle(1);
      end else begin
        clr_exp();
        e_busy = 1'b1; e_wr = 1'b1; e_idx = 2'(tgt); e_ack = 1'b1;
        tick();
        m_ent[tgt] = '{valid: 1'b1, dirty: d, line_addr: a};
        if (ff) m_fifo = (m_fifo + 1) % N;
      end
    end
    clr_exp();
    evict_valid = 1'b0; evict_dirty = 1'b0;
  endtask

  task automatic do_swap(input logic [W-1:0] la, input logic v, input logic d, input logic [W-1:0] ea);
    int mi;
    mi = 0;
    for (int i = N - 1; i >= 0; i--) if (m_ent[i].valid && m_ent[i].line_addr == la) mi = i;
    lookup_addr = la; swap_req = 1'b1; evict_valid = v; evict_dirty = d; evict_addr = ea;
    clr_exp(); e_rd = 1'b1; e_idx = 2'(mi);
    tick();
    swap_req = 1'b0;
    clr_exp(); e_busy = 1'b1; e_wr = v; e_idx = 2'(mi);
    tick();
    if (v) m_ent[mi] = '{valid: 1'b1, dirty: d, line_addr: ea};
    else m_ent[mi] = '{valid: 1'b0, dirty: 1'b0, line_addr: m_ent[mi].line_addr};
    clr_exp(); e_ack = 1'b1;
    tick();
    clr_exp();
    evict_valid = 1'b0;
  endtask

  task automatic do_flush(input int memdly);
    vc_flush = 1'b1;
    clr_exp();
    tick();
    vc_flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      clr_exp(); e_busy = 1'b1;
      tick();
      if (m_ent[i].valid && m_ent[i].dirty) begin
        wb_q.push_back(m_ent[i].line_addr);
        for (int c = 1; c <= memdly; c++) begin
          clr_exp();
          e_busy = 1'b1; e_req = 1'b1; e_mwr = 1'b1; e_rd = 1'b1;
          e_idx = 2'(i); e_maddr = m_ent[i].line_addr;
          mem_ack = (c == memdly);
          tick();
          mem_ack = 1'b0;
        end
      end
      m_ent[i].valid = 1'b0;
      m_ent[i].dirty = 1'b0;
    end
    clr_exp(); e_busy = 1'b1; e_ack = 1'b1;
    tick();
    m_fifo = 0;
    clr_exp();
  endtask

  initial begin
    do_reset();
    // Reset state: every output low with a lookup applied.
    lookup_addr = 26'h0000100;
    @(negedge clk);
    chk("rst_hit", {31'd0, vc_hit}, 32'd0);
    chk("rst_hit_idx", {30'd0, vc_hit_idx}, 32'd0);
    chk("rst_outs", {22'd0, data_rd, data_wr, vc_idx, ack, busy, mreq, mwr, mkill, 1'b0}, 32'd0);
    chk("rst_maddr", {6'd0, maddr}, 32'd0);
    tick();

    // Clean inserts into empty slots, stray memory ack, no-op insert.
    do_insert(26'h100, 1'b0, 1'b1, 0, 0);
    do_insert(26'h200, 1'b0, 1'b1, 0, 0);
    do_insert(26'h300, 1'b0, 1'b1, 0, 0);
    look("lk200", 26'h200, 1'b1, 2'd1);
    mem_ack = 1'b1;
    idle(1);
    mem_ack = 1'b0;
    do_insert(26'h777, 1'b1, 1'b0, 0, 0);
    look("lk777", 26'h777, 1'b0, 2'd0);

    // Full dirty cache: round-robin victims with write-back.
    do_reset();
    do_insert(26'h1000, 1'b1, 1'b1, 0, 0);
    do_insert(26'h2000, 1'b1, 1'b1, 0, 0);
    do_insert(26'h3000, 1'b1, 1'b1, 0, 0);
    do_insert(26'h4000, 1'b1, 1'b1, 0, 0);
    do_insert(26'h5000, 1'b1, 1'b1, 3, 0);
    look("lkE", 26'h5000, 1'b1, 2'd0);
    look("lkA", 26'h1000, 1'b0, 2'd0);
    do_insert(26'h6000, 1'b1, 1'b1, 2, 0);
    look("lkF", 26'h6000, 1'b1, 2'd1);
    look("lkB", 26'h2000, 1'b0, 2'd0);
    chk("wb_cnt", wb_q.size(), 32'd2);
    if (wb_q.size() == 2) begin
      chk("wb0", {6'd0, wb_q[0]}, 32'h1000);
      chk("wb1", {6'd0, wb_q[1]}, 32'h2000);
    end

    // Swap: 0x300 leaves entry 2, clean 0x500 takes its place.
    do_reset();
    do_insert(26'h100, 1'b0, 1'b1, 0, 0);
    do_insert(26'h200, 1'b0, 1'b1, 0, 0);
    do_insert(26'h300, 1'b0, 1'b1, 0, 0);
    do_swap(26'h300, 1'b1, 1'b0, 26'h500);
    look("lk500", 26'h500, 1'b1, 2'd2);
    look("lk300", 26'h300, 1'b0, 2'd0);
    do_swap(26'h100, 1'b0, 1'b0, 26'h0);
    look("lk100", 26'h100, 1'b0, 2'd0);

    // Flush with entries 1 and 3 dirty.
    do_reset();
    do_insert(26'h0100, 1'b0, 1'b1, 0, 0);
    do_insert(26'h1100, 1'b1, 1'b1, 0, 0);
    do_insert(26'h2100, 1'b0, 1'b1, 0, 0);
    do_insert(26'h3100, 1'b1, 1'b1, 0, 0);
    do_flush(2);
    chk("fl_cnt", wb_q.size(), 32'd2);
    if (wb_q.size() == 2) begin
      chk("fl0", {6'd0, wb_q[0]}, 32'h1100);
      chk("fl1", {6'd0, wb_q[1]}, 32'h3100);
    end
    look("fl_lk0", 26'h0100, 1'b0, 2'd0);
    look("fl_lk3", 26'h3100, 1'b0, 2'd0);

    // Kill during write-back keeps the victim; retry redoes the write-back.
    do_reset();
    do_insert(26'h1000, 1'b1, 1'b1, 0, 0);
    do_insert(26'h2000, 1'b1, 1'b1, 0, 0);
    do_insert(26'h3000, 1'b1, 1'b1, 0, 0);
    do_insert(26'h4000, 1'b1, 1'b1, 0, 0);
    do_insert(26'h5000, 1'b1, 1'b1, 3, 2);
    look("kl_A", 26'h1000, 1'b1, 2'd0);
    look("kl_E", 26'h5000, 1'b0, 2'd0);
    do_insert(26'h5000, 1'b1, 1'b1, 1, 0);
    look("kl_E2", 26'h5000, 1'b1, 2'd0);
    chk("kl_wbcnt", wb_q.size(), 32'd2);
    if (wb_q.size() == 2) chk("kl_wb", {6'd0, wb_q[1]}, 32'h1000);
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/victim_cache_ctrl.md
Name: victim_cache_ctrl

Overview:
Controller for the small fully-associative victim cache that sits beside the write-back data cache. It holds the tag, valid and dirty state for each victim entry and sequences the victim data array. It services line lookups, swaps, inserts and flushes from the dcache controller. Dirty victims it displaces are written back to data memory through the shared dcache memory handshake.

Parameters:
VC_ENTRIES, 4, number of victim entries; power of two, minimum 2.
LINE_ADDR_BITS, 26, line address width (32-bit address, 64 B line).
VC_IDX_BITS, $clog2(VC_ENTRIES), entry index width.

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
lookup_addr_i  in  LINE_ADDR_BITS  line address of the current dcache request
vc_hit_o  out  1  combinational hit for lookup_addr_i
vc_hit_idx_o  out  VC_IDX_BITS  matching entry
swap_req_i  in  1  move the hit line into dcache and install the evicted line in its slot
insert_req_i  in  1  insert the evicted dcache line
evict_valid_i  in  1  evicted dcache line is valid
evict_dirty_i  in  1  evicted line is dirty
evict_addr_i  in  LINE_ADDR_BITS  evicted line address
vc_flush_i  in  1  write back all dirty entries and invalidate them
kill_i  in  1  abort the current operation
vc_data_rd_o  out  1  victim data array read strobe
vc_data_wr_o  out  1  victim data array write strobe
vc_idx_o  out  VC_IDX_BITS  data array entry index
vc2dcache_ack_o  out  1  operation complete, single-cycle pulse
vc_busy_o  out  1  state is not VC_IDLE
vc2mem_req_o  out  1  memory request
vc2mem_wr_o  out  1  memory write
vc2mem_addr_o  out  LINE_ADDR_BITS  write-back line address
vc2mem_kill_o  out  1  abort the outstanding memory request
mem2vc_ack_i  in  1  memory acknowledge

Behaviour:
- Reset: all valid and dirty bits are 0, fifo_ptr is 0, state is VC_IDLE. Every output is 0, including vc_hit_o.
- Lookup is combinational in every state: hit = OR over i of (valid[i] & tag[i]==lookup_addr_i). vc_hit_idx_o is the lowest matching index. Tags are unique by construction.
- States: VC_IDLE, VC_SWAP, VC_WB, VC_INSERT, VC_FLUSH, VC_FLUSH_WB, VC_DONE.
- VC_IDLE priority: flush > swap > insert. Swap and insert asserted together is illegal; swap wins and a bench assertion flags it.
- Swap requires vc_hit_o = 1; swap_req_i without a hit is ignored.
  - IDLE: vc_data_rd_o=1, vc_idx_o=hit idx, latch the idx, go to VC_SWAP.
  - VC_SWAP with evict_valid_i=1: write tag=evict_addr_i, dirty=evict_dirty_i, valid=1, vc_data_wr_o=1.
  - VC_SWAP with evict_valid_i=0: clear valid.
  - VC_SWAP then pulses ack and returns to IDLE. Ack arrives 2 cycles after the request; fifo_ptr is unchanged.
- Insert with evict_valid_i=0: ack next cycle, no state change.
- Insert target: the lowest invalid entry. If every entry is valid, the target is fifo_ptr.
  - Target valid and dirty: go to VC_WB.
  - Otherwise go to VC_INSERT; a clean displaced line is dropped.
- VC_WB:
  - Hold vc2mem_req_o=vc2mem_wr_o=1, vc2mem_addr_o=tag[target], vc_data_rd_o=1, vc_idx_o=target.
  - On mem2vc_ack_i, go to VC_INSERT.
- VC_INSERT:
  - Write the entry with vc_data_wr_o=1 and pulse ack.
  - If the target came from fifo_ptr, fifo_ptr increments modulo VC_ENTRIES (natural wrap).
  - Return to IDLE.
- Flush:
  - VC_FLUSH scans scan_idx from 0 to VC_ENTRIES-1. A valid dirty entry goes to VC_FLUSH_WB, which uses the same handshake as VC_WB.
  - After the ack, or immediately if the entry is clean, clear valid and dirty and increment scan_idx.
  - After the last index, go to VC_DONE: pulse ack, reset fifo_ptr to 0, return to IDLE.
- kill_i in any non-IDLE state:
  - Next state is IDLE; the current cycle's tag, valid and dirty updates and data strobes are suppressed; no ack.
  - vc2mem_kill_o=1 if in VC_WB or VC_FLUSH_WB.
  - Entries already cleaned by an interrupted flush stay invalid; every other entry is unchanged.
- mem2vc_ack_i outside VC_WB and VC_FLUSH_WB is ignored.
- A write-back is always complete before the slot is overwritten, so no dirty data is ever lost.

Decomposition:
- Package vc_pkg holds:
  - enum type_vc_states_e;
  - VC_ENTRIES_DEF and LINE_ADDR_BITS_DEF;
  - struct type_vc_tag_s {valid, dirty, line_addr}.
- One sub-module, vc_tag_match: the parallel compare plus priority encoder. It yields hit, hit_idx, any_invalid and first_invalid_idx, and is reused for insert target selection.

Test Plan:
- Reset, then lookup 0x0000100: vc_hit_o=0 and every output is 0.
- Insert 0x100, 0x200, 0x300 clean: entries 0, 1, 2 filled, each ack 1 cycle after the request, no memory request. Lookup 0x200 gives hit=1, idx=1.
- Fill all 4 entries with dirty lines A–D, then insert E: memory write with addr=A, held for a 3-cycle memory delay. E is written to entry 0 and fifo_ptr becomes 1. Inserting F displaces B.
- With 0x300 at entry 2, swap evicting clean 0x500: rd strobe with idx=2, then wr strobe with idx=2. Ack arrives 2 cycles after the request; lookup 0x500 hits at idx 2 and 0x300 misses.
- Flush with entries 1 and 3 dirty: exactly two memory writes, in address order of idx 1 then idx 3. Ack pulses once and all valid bits end at 0.
- kill_i during VC_WB: vc2mem_kill_o=1, IDLE next cycle, no ack. The target entry keeps its tag and dirty bit, and a repeated insert redoes the write-back.
